rom_loader: RTL and testbench

- Upstream feeder of the instruction ROM's write port.
- Takes the byte stream from the UART receiver, parses a framed program image, assembles little-endian 32-bit words and issues single-cycle ROM writes.
- Holds the CPU core in reset while a load is in progress.
- Reports completion, and reports errors for bad length, checksum mismatch or timeout.

---
 rtl/rom_loader_pkg.sv | 24 ++
 rtl/rom_loader_word_asm.sv | 60 ++++++
 rtl/rom_loader.sv | 177 +++++++++++++++++
 tb/tb_rom_loader.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rom_loader_pkg
// Description : Shared widths, sync marker default and loader FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package rom_loader_pkg;

    localparam int         INST_ADDR_BUS  = 32;
    localparam int         INST_DATA_BUS  = 32;
    localparam logic [7:0] SYNC_BYTE_DFLT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_LEN  = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } state_e;

endpackage
`default_nettype wire

// File: rtl/rom_loader_word_asm.sv
`default_nettype none
// ============================================================================
// Module      : rom_loader_word_asm
// Description : Little-endian byte-to-word assembler with running 8-bit sum.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_loader_word_asm
    import rom_loader_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_i,
    input  logic                     byte_valid_i,
    input  logic                     csum_en_i,
    input  logic [7:0]               byte_i,
    output logic [INST_DATA_BUS-1:0] word_o,
    output logic                     word_done_o,
    output logic [7:0]               csum_o
);

    // Only the three earlier bytes are stored; the fourth is taken live.
    logic [INST_DATA_BUS-9:0] word_q, word_d;
    logic [1:0]               idx_q, idx_d;
    logic [7:0]               csum_q, csum_d;

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        csum_d = csum_q;
        if (clear_i) begin
            word_d = '0;
            idx_d  = '0;
            csum_d = '0;
        end else if (byte_valid_i) begin
            word_d = {byte_i, word_q[INST_DATA_BUS-9:8]};
            idx_d  = idx_q + 2'd1;
            if (csum_en_i) begin
                csum_d = csum_q + byte_i;
            end
        end
    end

    assign word_o      = {byte_i, word_q};
    assign word_done_o = byte_valid_i && (idx_q == 2'd3);
    assign csum_o      = csum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            idx_q  <= '0;
            csum_q <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
            csum_q <= csum_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rom_loader.sv
`default_nettype none
// ============================================================================
// Module      : rom_loader
// Description : Parses a framed UART program image and writes it into the ROM.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int                       ROM_NUM        = 4096,
    parameter logic [INST_ADDR_BUS-1:0] BASE_ADDR      = 32'h0000_0000,
    parameter logic [7:0]               SYNC_BYTE      = SYNC_BYTE_DFLT,
    parameter int                       TIMEOUT_CYCLES = 1_000_000
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic [7:0]               rx_data_i,
    input  logic                     rx_valid_i,
    output logic                     rx_ready_o,
    output logic                     wr_en_o,
    output logic [INST_ADDR_BUS-1:0] wr_addr_o,
    output logic [INST_DATA_BUS-1:0] wr_data_o,
    output logic                     hold_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic [31:0]              word_cnt_o
);

    state_e                   state_q, state_d;
    logic [31:0]              len_q, len_d;
    logic [31:0]              word_cnt_q, word_cnt_d;
    logic [31:0]              tmo_q, tmo_d;
    logic                     wr_en_q, wr_en_d;
    logic [INST_ADDR_BUS-1:0] wr_addr_q, wr_addr_d;
    logic [INST_DATA_BUS-1:0] wr_data_q, wr_data_d;
    logic                     err_q, err_d;

    logic                     accept;
    logic                     asm_clear;
    logic                     asm_valid;
    logic                     asm_csum_en;
    logic                     asm_done;
    logic [INST_DATA_BUS-1:0] asm_word;
    logic [7:0]               asm_csum;

    // The same assembler parses the length field; only payload feeds the sum.
    rom_loader_word_asm u_word_asm (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (asm_clear),
        .byte_valid_i (asm_valid),
        .csum_en_i    (asm_csum_en),
        .byte_i       (rx_data_i),
        .word_o       (asm_word),
        .word_done_o  (asm_done),
        .csum_o       (asm_csum)
    );

    assign rx_ready_o = (state_q == ST_SYNC) || (state_q == ST_LEN) ||
                        (state_q == ST_DATA) || (state_q == ST_CSUM);
    assign accept     = rx_valid_i && rx_ready_o;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_cnt_d  = word_cnt_q;
        tmo_d       = tmo_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        err_d       = err_q;
        asm_clear   = 1'b0;
        asm_valid   = 1'b0;
        asm_csum_en = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d    = ST_SYNC;
                    err_d      = 1'b0;
                    word_cnt_d = '0;
                    asm_clear  = 1'b1;
                end
            end
            ST_SYNC: begin
                if (accept && (rx_data_i == SYNC_BYTE)) begin
                    state_d = ST_LEN;
                    tmo_d   = '0;
                end
            end
            ST_LEN: begin
                asm_valid = accept;
                if (asm_done) begin
                    len_d = asm_word;
                    if (asm_word > 32'(ROM_NUM)) begin
                        state_d = ST_ERR;
                    end else if (asm_word == '0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                asm_valid   = accept;
                asm_csum_en = 1'b1;
                if (asm_done) begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = BASE_ADDR + {word_cnt_q[29:0], 2'b00};
                    wr_data_d  = asm_word;
                    word_cnt_d = word_cnt_q + 32'd1;
                    if (word_cnt_q == len_q - 32'd1) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    state_d = (rx_data_i == asm_csum) ? ST_DONE : ST_ERR;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Idle-gap watchdog; only armed once the sync marker has been seen.
        if ((state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM)) begin
            if (accept) begin
                tmo_d = '0;
            end else if (tmo_q == 32'(TIMEOUT_CYCLES - 1)) begin
                state_d = ST_ERR;
            end else begin
                tmo_d = tmo_q + 32'd1;
            end
        end

        if (state_d == ST_ERR) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            word_cnt_q <= '0;
            tmo_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            tmo_q      <= tmo_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            err_q      <= err_d;
        end
    end

    assign wr_en_o    = wr_en_q;
    assign wr_addr_o  = wr_addr_q;
    assign wr_data_o  = wr_data_q;
    assign hold_o     = (state_q != ST_IDLE);
    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = (state_q == ST_DONE);
    assign err_o      = err_q;
    assign word_cnt_o = word_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rom_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_loader
// Description : Self-checking bench for rom_loader (vectors, random frames, corners).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_loader;

    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [7:0]  rx_data_i = 8'h00;
    logic        rx_valid_i = 1'b0;
    logic        rx_ready_o, wr_en_o, hold_o, busy_o, done_o, err_o;
    logic [31:0] wr_addr_o, wr_data_o, word_cnt_o;

    rom_loader #(
        .ROM_NUM        (4096),
        .BASE_ADDR      (32'h0000_0000),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .rx_data_i  (rx_data_i),
        .rx_valid_i (rx_valid_i),
        .rx_ready_o (rx_ready_o),
        .wr_en_o    (wr_en_o),
        .wr_addr_o  (wr_addr_o),
        .wr_data_o  (wr_data_o),
        .hold_o     (hold_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .word_cnt_o (word_cnt_o)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    int          got_cyc[$];
    logic [7:0]  frame_q[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    bit          exp_done, exp_err;
    int          exp_cnt;

    typedef struct {
        string       name;
        logic [127:0] bytes;
        int          nb;
        int          nwr;
        logic [31:0] d0;
        logic [31:0] d1;
        bit          done;
        bit          err;
        int          cnt;
    } vec_t;
    vec_t vecs[6];

    always @(negedge clk) begin
        cyc++;
        if (wr_en_o === 1'b1) begin
            got_addr.push_back(wr_addr_o);
            got_data.push_back(wr_data_o);
            got_cyc.push_back(cyc);
        end
        if (done_o === 1'b1) done_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int k, input string name, input logic [127:0] b, input int nb,
                           input int nwr, input logic [31:0] d0, input logic [31:0] d1,
                           input bit done, input bit err, input int cnt);
        vecs[k].name = name;  vecs[k].bytes = b;  vecs[k].nb = nb;
        vecs[k].nwr = nwr;    vecs[k].d0 = d0;    vecs[k].d1 = d1;
        vecs[k].done = done;  vecs[k].err = err;  vecs[k].cnt = cnt;
    endtask

    // Offer one byte (optionally after an idle gap); returns just after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        if (gap > 0) begin
            rx_valid_i = 1'b0;
            repeat (gap) @(negedge clk);
        end else begin
            @(negedge clk);
        end
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        waited = 0;
        while (!rx_ready_o && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        if (!rx_ready_o) begin
            checks++;
            failures++;
            $display("FAIL rx_ready wait: got 0 expected 1 for byte 0x%02h", b);
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("busy after start", 32'(busy_o), 32'd1);
        check("hold after start", 32'(hold_o), 32'd1);
        check("err cleared by start", 32'(err_o), 32'd0);
        check("word_cnt cleared by start", word_cnt_o, 32'd0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_o && n < TMO + 50) begin
            @(negedge clk);
            n++;
        end
        if (busy_o) begin
            checks++;
            failures++;
            $display("FAIL idle wait: busy_o still 1 after %0d cycles, expected 0", n);
        end
        @(negedge clk);
    endtask

    task automatic drive_frame(input bit gaps);
        got_addr.delete();
        got_data.delete();
        got_cyc.delete();
        done_cnt = 0;
        pulse_start();
        foreach (frame_q[i]) send_byte(frame_q[i], gaps ? int'($urandom_range(0, 3)) : 0);
        rx_valid_i = 1'b0;
        wait_idle();
        check("hold released", 32'(hold_o), 32'd0);
        if (!gaps) begin
            for (int i = 1; i < got_cyc.size(); i++)
                check("streaming write spacing", 32'(got_cyc[i] - got_cyc[i-1]), 32'd4);
        end
    endtask

    // Straight sequential parse of the frame according to the image format.
    task automatic model_frame();
        int          p, sz;
        logic [31:0] n, w;
        logic [7:0]  sum;
        exp_addr.delete();
        exp_data.delete();
        exp_done = 0;
        exp_err  = 0;
        exp_cnt  = 0;
        sum = 8'h00;
        sz  = frame_q.size();
        p   = 0;
        while (p < sz && frame_q[p] != 8'hA5) p++;
        p++;
        if (p + 4 > sz) begin exp_err = 1; return; end
        n = {frame_q[p+3], frame_q[p+2], frame_q[p+1], frame_q[p]};
        p += 4;
        if (n > 32'd4096) begin exp_err = 1; return; end
        for (int i = 0; i < int'(n); i++) begin
            if (p + 4 > sz) begin exp_err = 1; return; end
            w = {frame_q[p+3], frame_q[p+2], frame_q[p+1], frame_q[p]};
            sum = sum + frame_q[p] + frame_q[p+1] + frame_q[p+2] + frame_q[p+3];
            exp_addr.push_back(32'(4 * i));
            exp_data.push_back(w);
            exp_cnt++;
            p += 4;
        end
        if (p >= sz) begin exp_err = 1; return; end
        if (frame_q[p] == sum) exp_done = 1;
        else exp_err = 1;
    endtask

    task automatic build_random();
        int          junk, mode;
        logic [31:0] n;
        logic [7:0]  b, sum;
        frame_q.delete();
        junk = $urandom_range(0, 3);
        repeat (junk) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h5A;
            frame_q.push_back(b);
        end
        frame_q.push_back(8'hA5);
        mode = $urandom_range(0, 9);
        n = (mode == 0) ? 32'(4097 + $urandom_range(0, 100)) : 32'($urandom_range(0, 6));
        for (int i = 0; i < 4; i++) frame_q.push_back(n[8*i +: 8]);
        if (n <= 32'd4096) begin
            sum = 8'h00;
            for (int i = 0; i < 4 * int'(n); i++) begin
                b = 8'($urandom_range(0, 255));
                frame_q.push_back(b);
                sum = sum + b;
            end
            if ($urandom_range(0, 3) == 0) sum = sum ^ 8'($urandom_range(1, 255));
            frame_q.push_back(sum);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_vec(0, "nominal",    128'hA5_02000000_13000000_6F000000_82, 14, 2, 32'h13, 32'h6F, 1, 0, 2);
        set_vec(1, "sync hunt",  128'hFF_00_A5_01000000_EFBEADDE_38,    12, 1, 32'hDEADBEEF, 32'h0, 1, 0, 1);
        set_vec(2, "csum error", 128'hA5_02000000_13000000_6F000000_83, 14, 2, 32'h13, 32'h6F, 0, 1, 2);
        set_vec(3, "oversize",   128'hA5_01100000,                       5, 0, 32'h0, 32'h0, 0, 1, 0);
        set_vec(4, "zero len",   128'hA5_00000000_00,                    6, 0, 32'h0, 32'h0, 1, 0, 0);
        set_vec(5, "zero badcs", 128'hA5_00000000_5A,                    6, 0, 32'h0, 32'h0, 0, 1, 0);

        repeat (3) @(negedge clk);
        check("reset rx_ready", 32'(rx_ready_o), 32'd0);
        check("reset wr_en", 32'(wr_en_o), 32'd0);
        check("reset wr_addr", wr_addr_o, 32'd0);
        check("reset wr_data", wr_data_o, 32'd0);
        check("reset hold", 32'(hold_o), 32'd0);
        check("reset busy", 32'(busy_o), 32'd0);
        check("reset done", 32'(done_o), 32'd0);
        check("reset err", 32'(err_o), 32'd0);
        check("reset word_cnt", word_cnt_o, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 6; k++) begin
            frame_q.delete();
            for (int i = 0; i < vecs[k].nb; i++)
                frame_q.push_back(vecs[k].bytes[8*(vecs[k].nb-1-i) +: 8]);
            drive_frame(1'b0);
            check({vecs[k].name, " write count"}, 32'(got_addr.size()), 32'(vecs[k].nwr));
            for (int j = 0; j < got_addr.size() && j < vecs[k].nwr; j++) begin
                check({vecs[k].name, " wr_addr"}, got_addr[j], 32'(4 * j));
                check({vecs[k].name, " wr_data"}, got_data[j], (j == 0) ? vecs[k].d0 : vecs[k].d1);
            end
            check({vecs[k].name, " done pulses"}, 32'(done_cnt), 32'(vecs[k].done));
            check({vecs[k].name, " err"}, 32'(err_o), 32'(vecs[k].err));
            check({vecs[k].name, " word_cnt"}, word_cnt_o, 32'(vecs[k].cnt));
        end

        for (int r = 0; r < 25; r++) begin
            bit gaps;
            gaps = ($urandom_range(0, 1) == 1);
            build_random();
            model_frame();
            drive_frame(gaps);
            check("rand write count", 32'(got_addr.size()), 32'(exp_addr.size()));
            for (int j = 0; j < got_addr.size() && j < exp_addr.size(); j++) begin
                check("rand wr_addr", got_addr[j], exp_addr[j]);
                check("rand wr_data", got_data[j], exp_data[j]);
            end
            check("rand done pulses", 32'(done_cnt), 32'(exp_done));
            check("rand err", 32'(err_o), 32'(exp_err));
            check("rand word_cnt", word_cnt_o, 32'(exp_cnt));
        end

        // Timeout: three words announced, payload stops after the fifth byte.
        begin
            int c;
            logic [7:0] tb_bytes[10] = '{8'hA5, 8'h03, 8'h00, 8'h00, 8'h00,
                                         8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
            got_addr.delete(); got_data.delete(); got_cyc.delete();
            done_cnt = 0;
            pulse_start();
            for (int i = 0; i < 10; i++) send_byte(tb_bytes[i], 0);
            rx_valid_i = 1'b0;
            c = 0;
            while (!err_o && c < TMO + 20) begin
                @(posedge clk);
                #1;
                c++;
            end
            check("timeout latency", 32'(c), 32'(TMO));
            wait_idle();
            check("timeout write count", 32'(got_addr.size()), 32'd1);
            if (got_addr.size() > 0) begin
                check("timeout wr_addr", got_addr[0], 32'h0);
                check("timeout wr_data", got_data[0], 32'h44332211);
            end
            check("timeout done pulses", 32'(done_cnt), 32'd0);
            check("timeout word_cnt", word_cnt_o, 32'd1);
            check("timeout hold", 32'(hold_o), 32'd0);
        end

        // Start ignored while busy, then reset mid-DATA.
        begin
            logic [7:0] rb[9] = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00,
                                  8'hAA, 8'hBB, 8'hCC, 8'hDD};
            got_addr.delete(); got_data.delete(); got_cyc.delete();
            done_cnt = 0;
            pulse_start();
            for (int i = 0; i < 9; i++) send_byte(rb[i], 0);
            start_i = 1'b1;
            send_byte(8'h11, 0);
            start_i = 1'b0;
            check("start ignored word_cnt", word_cnt_o, 32'd1);
            check("start ignored busy", 32'(busy_o), 32'd1);
            rx_data_i = 8'h22;
            rst = 1'b1;
            #1;
            check("midload reset wr_en", 32'(wr_en_o), 32'd0);
            check("midload reset hold", 32'(hold_o), 32'd0);
            check("midload reset busy", 32'(busy_o), 32'd0);
            check("midload reset rx_ready", 32'(rx_ready_o), 32'd0);
            check("midload reset word_cnt", word_cnt_o, 32'd0);
            check("midload reset wr_data", wr_data_o, 32'd0);
            repeat (3) @(negedge clk);
            rst = 1'b0;
            repeat (10) @(negedge clk);
            check("midload writes", 32'(got_addr.size()), 32'd1);
            if (got_data.size() > 0) check("midload wr_data", got_data[0], 32'hDDCCBBAA);
            check("idle byte not taken", 32'(rx_ready_o), 32'd0);
            check("idle after reset busy", 32'(busy_o), 32'd0);
            rx_valid_i = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
